// File: rtl/writeback_register_file_if.sv
// Writeback/decode-side bus for the register file: write request, read indices and read results.
interface writeback_register_file_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;

  logic [IDX_W-1:0]  WB_write_reg_1;
  logic [DATA_W-1:0] WB_alu_result;
  logic [DATA_W-1:0] WB_dm_read_data;
  logic              WB_rm_write_data_source;
  logic              WB_rm_write_enable;
  logic [IDX_W-1:0]  ID_read_reg_1;
  logic [IDX_W-1:0]  ID_read_reg_2;
  logic [DATA_W-1:0] ID_read_data_1;
  logic [DATA_W-1:0] ID_read_data_2;
  logic [DATA_W-1:0] WB_write_data;
  logic [DATA_W-1:0] wb_commit_count;

  // Pipeline side: issues writes and read indices, consumes read data.
  modport master (
    output WB_write_reg_1, WB_alu_result, WB_dm_read_data,
           WB_rm_write_data_source, WB_rm_write_enable,
           ID_read_reg_1, ID_read_reg_2,
    input  ID_read_data_1, ID_read_data_2, WB_write_data, wb_commit_count
  );

  // Register file side.
  modport slave (
    input  WB_write_reg_1, WB_alu_result, WB_dm_read_data,
           WB_rm_write_data_source, WB_rm_write_enable,
           ID_read_reg_1, ID_read_reg_2,
    output ID_read_data_1, ID_read_data_2, WB_write_data, wb_commit_count
  );
endinterface

// File: rtl/writeback_register_file.sv
// 32x32 register file with writeback data select, optional write-to-read bypass
// and a commit counter. Register 0 is hardwired to zero.
module writeback_register_file #(
  parameter int unsigned BYPASS_EN = 1
) (
  input logic                       clock,
  input logic                       reset,
  writeback_register_file_if.slave  bus
);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_commit_count;
  logic [DATA_W-1:0] w_write_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_read_data_1;
  logic [DATA_W-1:0] w_read_data_2;

  // Select writeback data between ALU result and memory load.
  always_comb begin
    w_write_data = bus.WB_alu_result;
    if (bus.WB_rm_write_data_source) begin
      w_write_data = bus.WB_dm_read_data;
    end
  end

  // A write commits only when enabled, aimed at a real register and outside reset;
  // the reset term also inhibits the bypass path below.
  assign w_commit = bus.WB_rm_write_enable
                  && (bus.WB_write_reg_1 != IDX_W'(0))
                  && !reset;

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[bus.WB_write_reg_1] <= w_write_data;
    end
  end

  // Count committed writes; wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_commit_count <= '0;
    end else if (w_commit) begin
      r_commit_count <= r_commit_count + DATA_W'(1);
    end
  end

  // Read port 1: array lookup with optional same-cycle bypass of the pending write.
  always_comb begin
    w_read_data_1 = r_regs[bus.ID_read_reg_1];
    if (bus.ID_read_reg_1 == IDX_W'(0)) begin
      w_read_data_1 = '0;
    end else if ((BYPASS_EN != 0) && w_commit
                 && (bus.ID_read_reg_1 == bus.WB_write_reg_1)) begin
      w_read_data_1 = w_write_data;
    end
  end

  // Read port 2: identical to port 1, bypass applied independently.
  always_comb begin
    w_read_data_2 = r_regs[bus.ID_read_reg_2];
    if (bus.ID_read_reg_2 == IDX_W'(0)) begin
      w_read_data_2 = '0;
    end else if ((BYPASS_EN != 0) && w_commit
                 && (bus.ID_read_reg_2 == bus.WB_write_reg_1)) begin
      w_read_data_2 = w_write_data;
    end
  end

  assign bus.ID_read_data_1  = w_read_data_1;
  assign bus.ID_read_data_2  = w_read_data_2;
  assign bus.WB_write_data   = w_write_data;
  assign bus.wb_commit_count = r_commit_count;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file share stimulus.
module tb_writeback_register_file;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  writeback_register_file_if bus_b ();
  writeback_register_file_if bus_n ();

  // Non-bypass instance mirrors the stimulus of the bypass instance.
  assign bus_n.WB_write_reg_1          = bus_b.WB_write_reg_1;
  assign bus_n.WB_alu_result           = bus_b.WB_alu_result;
  assign bus_n.WB_dm_read_data         = bus_b.WB_dm_read_data;
  assign bus_n.WB_rm_write_data_source = bus_b.WB_rm_write_data_source;
  assign bus_n.WB_rm_write_enable      = bus_b.WB_rm_write_enable;
  assign bus_n.ID_read_reg_1           = bus_b.ID_read_reg_1;
  assign bus_n.ID_read_reg_2           = bus_b.ID_read_reg_2;

  writeback_register_file #(.BYPASS_EN(1)) dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));
  writeback_register_file #(.BYPASS_EN(0)) dut_n (.clock(clock), .reset(reset), .bus(bus_n.slave));

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] wreg, input logic src, input logic en,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus_b.WB_write_reg_1          = wreg;
    bus_b.WB_rm_write_data_source = src;
    bus_b.WB_rm_write_enable      = en;
    bus_b.WB_alu_result           = alu;
    bus_b.WB_dm_read_data         = dm;
    bus_b.ID_read_reg_1           = r1;
    bus_b.ID_read_reg_2           = r2;
    #1;
  endtask

  // Advance to the next falling edge, passing exactly one rising edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] val;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;

    // Reset state, and writes/bypass suppressed while reset is high.
    drive(5'd5, 1'b0, 1'b1, 32'hAAAA_5555, 32'h0, 5'd5, 5'd5);
    check("rst_count", bus_b.wb_commit_count, 32'h0);
    check("rst_bypass_inhibit", bus_b.ID_read_data_1, 32'h0);
    tick();
    #1;
    check("rst_write_suppressed", bus_b.ID_read_data_2, 32'h0);
    check("rst_count_hold", bus_b.wb_commit_count, 32'h0);

    // Release reset at a falling edge; first write lands on the next rising edge.
    reset = 1'b0;
    drive(5'd5, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
    check("wdata_alu", bus_b.WB_write_data, 32'h1234_5678);
    check("bypass_r5", bus_b.ID_read_data_1, 32'h1234_5678);
    check("nobypass_r5_pre", bus_n.ID_read_data_1, 32'h0);
    tick();
    drive(5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
    check("read_r5_p1", bus_b.ID_read_data_1, 32'h1234_5678);
    check("read_r5_p2", bus_n.ID_read_data_2, 32'h1234_5678);
    check("count_1", bus_b.wb_commit_count, 32'h1);

    // Writes to register 0 are dropped and not counted.
    drive(5'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0);
    check("r0_no_bypass", bus_b.ID_read_data_1, 32'h0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    check("r0_read", bus_b.ID_read_data_2, 32'h0);
    check("r0_count", bus_b.wb_commit_count, 32'h1);

    // Register 7 preset to 1, then memory-sourced write with both ports reading it.
    drive(5'd7, 1'b0, 1'b1, 32'h1, 32'h0, 5'd0, 5'd0);
    tick();
    drive(5'd7, 1'b1, 1'b1, 32'h5555_0000, 32'hCAFE_F00D, 5'd7, 5'd7);
    check("wdata_mem", bus_b.WB_write_data, 32'hCAFE_F00D);
    check("bypass_r7_p1", bus_b.ID_read_data_1, 32'hCAFE_F00D);
    check("bypass_r7_p2", bus_b.ID_read_data_2, 32'hCAFE_F00D);
    check("nobypass_r7_p1_pre", bus_n.ID_read_data_1, 32'h1);
    check("nobypass_r7_p2_pre", bus_n.ID_read_data_2, 32'h1);
    // Independent ports: port 1 reads a stored register while port 2 bypasses.
    drive(5'd7, 1'b1, 1'b1, 32'h5555_0000, 32'hCAFE_F00D, 5'd5, 5'd7);
    check("indep_p1_stored", bus_b.ID_read_data_1, 32'h1234_5678);
    check("indep_p2_bypass", bus_b.ID_read_data_2, 32'hCAFE_F00D);
    tick();
    drive(5'd7, 1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7);
    check("nobypass_r7_post", bus_n.ID_read_data_1, 32'hCAFE_F00D);
    check("bypass_r7_post", bus_b.ID_read_data_2, 32'hCAFE_F00D);
    check("count_3", bus_b.wb_commit_count, 32'h3);

    // Disabled write to register 3 changes nothing.
    drive(5'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd3, 5'd3);
    check("dis_no_bypass", bus_b.ID_read_data_1, 32'h0);
    tick();
    #1;
    check("dis_r3", bus_b.ID_read_data_2, 32'h0);
    check("dis_count", bus_b.wb_commit_count, 32'h3);

    // Fill registers 1..31 with distinct values and read them back.
    for (int i = 1; i < 32; i++) begin
      val = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      drive(5'(i), 1'b0, 1'b1, val, 32'h0, 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      val = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
      check($sformatf("fill_r%0d", i), bus_b.ID_read_data_1, val);
    end
    check("fill_count", bus_b.wb_commit_count, 32'd34);

    // Asynchronous reset between edges clears everything immediately.
    #1;
    reset = 1'b1;
    #1;
    check("arst_count", bus_b.wb_commit_count, 32'h0);
    for (int i = 1; i < 32; i += 5) begin
      drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(i));
      check($sformatf("arst_r%0d", i), bus_n.ID_read_data_2, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;

    // First write after reset is accepted on the first rising edge.
    drive(5'd9, 1'b0, 1'b1, 32'h0BAD_F00D, 32'h0, 5'd9, 5'd31);
    tick();
    drive(5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd31);
    check("post_rst_r9", bus_n.ID_read_data_1, 32'h0BAD_F00D);
    check("post_rst_r31", bus_b.ID_read_data_2, 32'h0);
    check("post_rst_count", bus_b.wb_commit_count, 32'h1);

    // Counter wrap: preload all-ones, then commit once more.
    force dut_b.r_commit_count = 32'hFFFF_FFFF;
    #1;
    release dut_b.r_commit_count;
    #1;
    check("wrap_preload", bus_b.wb_commit_count, 32'hFFFF_FFFF);
    drive(5'd2, 1'b0, 1'b1, 32'h2222_2222, 32'h0, 5'd2, 5'd0);
    tick();
    drive(5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 5'd2, 5'd0);
    check("wrap_count", bus_b.wb_commit_count, 32'h0);
    check("wrap_r2", bus_b.ID_read_data_1, 32'h2222_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
